// File: rtl/cond_reg_file.sv
// rtl/cond_reg_file.sv - conditional register file with NZCV flag register
module cond_reg_file #(
    parameter int W  = 4,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] ra1,
    input  logic [AW-1:0] ra2,
    output logic [W-1:0]  rd1,
    output logic [W-1:0]  rd2,
    input  logic [AW-1:0] wa,
    input  logic [W-1:0]  wd,
    input  logic          we,
    input  logic          flag_we,
    input  logic [3:0]    cond,
    input  logic          alu_n,
    input  logic          alu_z,
    input  logic          alu_co,
    input  logic          alu_ovf,
    output logic [3:0]    flags,
    output logic          cond_pass
);

    localparam int DEPTH = 1 << AW;

    logic [W-1:0] regs [DEPTH];
    logic         flag_n;
    logic         flag_z;
    logic         flag_c;
    logic         flag_v;

    // Reads show the stored contents; a same-cycle write is not bypassed.
    assign rd1 = regs[ra1];
    assign rd2 = regs[ra2];

    assign flag_n = flags[3];
    assign flag_z = flags[2];
    assign flag_c = flags[1];
    assign flag_v = flags[0];

    // Evaluate the condition code against the held flags only, never the ALU flags.
    always_comb begin
        cond_pass = 1'b0;
        case (cond)
            4'b0000: cond_pass = flag_z;
            4'b0001: cond_pass = !flag_z;
            4'b0010: cond_pass = flag_c;
            4'b0011: cond_pass = !flag_c;
            4'b0100: cond_pass = flag_n;
            4'b0101: cond_pass = !flag_n;
            4'b0110: cond_pass = flag_v;
            4'b0111: cond_pass = !flag_v;
            4'b1000: cond_pass = flag_c && !flag_z;
            4'b1001: cond_pass = !flag_c || flag_z;
            4'b1010: cond_pass = (flag_n == flag_v);
            4'b1011: cond_pass = (flag_n != flag_v);
            4'b1100: cond_pass = !flag_z && (flag_n == flag_v);
            4'b1101: cond_pass = flag_z || (flag_n != flag_v);
            4'b1110: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end

    // Register array: cleared asynchronously, written only when the condition holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (we && cond_pass) begin
            regs[wa] <= wd;
        end
    end

    // Flag register: the new flags only influence cond_pass from the next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags <= 4'b0000;
        end else if (flag_we && cond_pass) begin
            flags <= {alu_n, alu_z, alu_co, alu_ovf};
        end
    end

endmodule
